// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer
//   Elastic buffer between two pipeline stages. It carries a 4-bit forwards
//   status code plus a DATA_W payload through a DEPTH-entry FIFO. It also
//   implements the backwards READY/STALL/JUMP handshake:
//     - stalls are propagated upstream when the buffer is full;
//     - JUMP flushes the buffer;
//     - the upstream stage is fenced off once an exception entry is accepted.
//
//   Optional feature: define PIPE_STAGE_BUFFER_BYPASS_EN to add a
//   zero-latency combinational path through an empty buffer.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   in_status  forwards status from upstream:
//                0 VALID, 1 BUBBLE, 2..10 exception, 11..15 unused
//   in_data    payload from upstream
//   up_ctrl    backwards control to upstream: 0 READY, 1 STALL, 2 JUMP
//   out_status forwards status to downstream (BUBBLE when empty)
//   out_data   payload to downstream (0 when empty)
//   down_ctrl  backwards control from downstream; code 3 acts as STALL
//   count      current occupancy
//   fenced     exception fence active
module pipe_stage_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        in_status,
  input  logic [DATA_W-1:0] in_data,
  output logic [1:0]        up_ctrl,
  output logic [3:0]        out_status,
  output logic [DATA_W-1:0] out_data,
  input  logic [1:0]        down_ctrl,
  output logic [CNT_W-1:0]  count,
  output logic              fenced
);

  localparam int         PTR_W      = $clog2(DEPTH);
  localparam logic [1:0] CTRL_READY = 2'd0;
  localparam logic [1:0] CTRL_STALL = 2'd1;
  localparam logic [1:0] CTRL_JUMP  = 2'd2;
  localparam logic [3:0] ST_BUBBLE  = 4'd1;

  // VALID and the exception codes are stored.
  // BUBBLE and the unused codes 11..15 are dropped.
  function automatic logic is_storable(input logic [3:0] s);
    return (s <= 4'd10) && (s != ST_BUBBLE);
  endfunction

  function automatic logic is_exception(input logic [3:0] s);
    return (s >= 4'd2) && (s <= 4'd10);
  endfunction

  // Payload storage is deliberately left unreset.
  // Reading it is gated by count, so stale contents are never visible.
  logic [3:0]        mem_status [DEPTH];
  logic [DATA_W-1:0] mem_data   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic down_jump;
  logic down_ready;
  logic full;
  logic accept;
  logic pop;
  logic push;
  logic bypass;

  assign down_jump  = (down_ctrl == CTRL_JUMP);
  assign down_ready = (down_ctrl == CTRL_READY);
  assign full       = (count == CNT_W'(DEPTH));

  always_comb begin
    up_ctrl = CTRL_READY;
    if (down_jump)
      up_ctrl = CTRL_JUMP;
    else if (full || fenced)
      up_ctrl = CTRL_STALL;
  end

  // READY already implies: no jump, not full, not fenced.
  assign accept = is_storable(in_status) && (up_ctrl == CTRL_READY);
  assign pop    = (count != '0) && down_ready;

`ifdef PIPE_STAGE_BUFFER_BYPASS_EN
  // An empty buffer with a ready consumer hands the input straight through.
  assign bypass = accept && (count == '0) && down_ready;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fenced <= 1'b0;
    end else if (down_jump) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fenced <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
      // Bypassed exceptions fence the upstream stage too.
      if (accept && is_exception(in_status))
        fenced <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_status[wr_ptr] <= in_status;
      mem_data[wr_ptr]   <= in_data;
    end
  end

  always_comb begin
    out_status = ST_BUBBLE;
    out_data   = '0;
    if (count != '0) begin
      out_status = mem_status[rd_ptr];
      out_data   = mem_data[rd_ptr];
    end else if (bypass) begin
      out_status = in_status;
      out_data   = in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
module tb_pipe_stage_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic [3:0]        in_status;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        up_ctrl;
  logic [3:0]        out_status;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        down_ctrl;
  logic [CNT_W-1:0]  count;
  logic              fenced;

  int checks   = 0;
  int failures = 0;

  pipe_stage_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_status(in_status), .in_data(in_data),
    .up_ctrl(up_ctrl), .out_status(out_status), .out_data(out_data),
    .down_ctrl(down_ctrl), .count(count), .fenced(fenced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of {status,data} ----------------
  logic [3+DATA_W:0] mq[$];
  bit                mf;

  function automatic bit m_storable(input logic [3:0] s);
    return (s == 4'd0) || (s >= 4'd2 && s <= 4'd10);
  endfunction

  function automatic logic [1:0] m_up();
    if (down_ctrl == 2'd2) return 2'd2;
    if (mq.size() == DEPTH || mf) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit m_bypass();
`ifdef PIPE_STAGE_BUFFER_BYPASS_EN
    return mq.size() == 0 && m_storable(in_status) && !mf && down_ctrl == 2'd0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    bit acc, byp, pp;
    if (rst) begin
      mq.delete();
      mf = 1'b0;
    end else if (down_ctrl == 2'd2) begin
      mq.delete();
      mf = 1'b0;
    end else begin
      acc = m_storable(in_status) && (m_up() == 2'd0);
      byp = acc && m_bypass();
      pp  = (mq.size() > 0) && (down_ctrl == 2'd0);
      if (pp) void'(mq.pop_front());
      if (acc && !byp) mq.push_back({in_status, in_data});
      if (acc && in_status != 4'd0) mf = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [3:0]        es;
    logic [DATA_W-1:0] ed;
    es = 4'd1;
    ed = '0;
    if (mq.size() > 0) begin
      es = mq[0][3+DATA_W:DATA_W];
      ed = mq[0][DATA_W-1:0];
    end else if (m_bypass()) begin
      es = in_status;
      ed = in_data;
    end
    chk("model_up_ctrl", 32'(up_ctrl), 32'(m_up()));
    chk("model_out_status", 32'(out_status), 32'(es));
    chk("model_out_data", 32'(out_data), 32'(ed));
    chk("model_count", 32'(count), 32'(mq.size()));
    chk("model_fenced", 32'(fenced), 32'(mf));
  end

  // ---------------- directed stimulus ----------------
  task automatic drv(input logic [3:0] s, input logic [7:0] d, input logic [1:0] c);
    in_status = s;
    in_data   = d;
    down_ctrl = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(4'd1, 8'h00, 2'd0);
    chk("rst_out_status", 32'(out_status), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_up_ctrl", 32'(up_ctrl), 32'd0);
    chk("idle_out_status", 32'(out_status), 32'd1);

    // Streaming
    drv(4'd0, 8'h11, 2'd0);
`ifdef PIPE_STAGE_BUFFER_BYPASS_EN
    chk("stream_byp_11", 32'(out_data), 32'h11);
`endif
    tick();
    drv(4'd0, 8'h22, 2'd0);
`ifndef PIPE_STAGE_BUFFER_BYPASS_EN
    chk("stream_11", 32'(out_data), 32'h11);
    chk("stream_cnt1", 32'(count), 32'd1);
`endif
    tick();
    drv(4'd0, 8'h33, 2'd0);
`ifndef PIPE_STAGE_BUFFER_BYPASS_EN
    chk("stream_22", 32'(out_data), 32'h22);
`endif
    tick();
    drv(4'd1, 8'h00, 2'd0);
`ifndef PIPE_STAGE_BUFFER_BYPASS_EN
    chk("stream_33", 32'(out_data), 32'h33);
`endif
    tick();
    chk("stream_end_bubble", 32'(out_status), 32'd1);

    // Backpressure (code 3 also acts as STALL)
    drv(4'd0, 8'h0A, 2'd1);
    tick();
    drv(4'd0, 8'h0B, 2'd3);
    chk("bp_cnt1", 32'(count), 32'd1);
    chk("bp_head_a", 32'(out_data), 32'h0A);
    tick();
    drv(4'd1, 8'h00, 2'd1);
    chk("bp_full", 32'(count), 32'd2);
    chk("bp_up_stall", 32'(up_ctrl), 32'd1);
    chk("bp_hold_a", 32'(out_data), 32'h0A);
    tick();
    drv(4'd1, 8'h00, 2'd0);
    chk("bp_rel_a", 32'(out_data), 32'h0A);
    tick();
    chk("bp_rel_b", 32'(out_data), 32'h0B);
    chk("bp_up_ready", 32'(up_ctrl), 32'd0);
    tick();
    chk("bp_drained", 32'(out_status), 32'd1);

    // Flush
    drv(4'd0, 8'h01, 2'd1);
    tick();
    drv(4'd0, 8'h02, 2'd1);
    tick();
    drv(4'd0, 8'h03, 2'd2);
    chk("flush_up_jump", 32'(up_ctrl), 32'd2);
    tick();
    drv(4'd1, 8'h00, 2'd0);
    chk("flush_cnt0", 32'(count), 32'd0);
    chk("flush_bubble", 32'(out_status), 32'd1);
    tick();

    // Exception fence
    drv(4'd0, 8'h05, 2'd0);
    tick();
    drv(4'd6, 8'h06, 2'd0);
`ifndef PIPE_STAGE_BUFFER_BYPASS_EN
    chk("fence_out5", 32'(out_data), 32'h05);
`endif
    tick();
    drv(4'd0, 8'h07, 2'd0);
    chk("fence_set", 32'(fenced), 32'd1);
    chk("fence_up_stall", 32'(up_ctrl), 32'd1);
`ifndef PIPE_STAGE_BUFFER_BYPASS_EN
    chk("fence_out6", 32'(out_status), 32'd6);
`endif
    tick();
    chk("fence_bubble", 32'(out_status), 32'd1);
    chk("fence_hold", 32'(fenced), 32'd1);
    tick();
    drv(4'd1, 8'h00, 2'd2);
    tick();
    drv(4'd0, 8'h08, 2'd0);
    chk("fence_cleared", 32'(fenced), 32'd0);
    chk("fence_up_ready", 32'(up_ctrl), 32'd0);
    tick();
    drv(4'd1, 8'h00, 2'd0);
`ifndef PIPE_STAGE_BUFFER_BYPASS_EN
    chk("fence_out8", 32'(out_data), 32'h08);
`endif
    tick();

    // Bypass / latency
    drv(4'd0, 8'h09, 2'd0);
`ifdef PIPE_STAGE_BUFFER_BYPASS_EN
    chk("byp_same_cycle", 32'(out_data), 32'h09);
    chk("byp_cnt0", 32'(count), 32'd0);
    tick();
    drv(4'd1, 8'h00, 2'd0);
    chk("byp_cnt_after", 32'(count), 32'd0);
`else
    chk("nobyp_same_cycle", 32'(out_status), 32'd1);
    tick();
    drv(4'd1, 8'h00, 2'd0);
    chk("nobyp_next_cycle", 32'(out_data), 32'h09);
`endif
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
